// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM encoding, instruction fields.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int WIDTH    = 16;
    localparam int NUM_REGS = 16;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 0;

    localparam logic [3:0] OP_ADD        = 4'd0;
    localparam logic [3:0] OP_SUB        = 4'd1;
    localparam logic [3:0] OP_SGT        = 4'd2;
    localparam logic [3:0] OP_AND        = 4'd3;
    localparam logic [3:0] OP_OR         = 4'd4;
    localparam logic [3:0] OP_XOR        = 4'd5;
    localparam logic [3:0] OP_ANDI       = 4'd6;
    localparam logic [3:0] OP_ORI        = 4'd7;
    localparam logic [3:0] OP_XORI       = 4'd8;
    localparam logic [3:0] OP_ADDI       = 4'd9;
    localparam logic [3:0] OP_SUBI       = 4'd10;
    localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [WIDTH-1:0] w);
        instr_t t;
        t.op = w[OP_MSB:OP_LSB];
        t.rd = w[RD_MSB:RD_LSB];
        t.rs = w[RS_MSB:RS_LSB];
        t.rt = w[RT_MSB:RT_LSB];
        return t;
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

    function automatic logic is_rtype(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic is_itype(input logic [3:0] op);
        return op inside {OP_SGT, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI};
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/return, retire status and debug read bundle.
// Latency: n/a (wiring only).
// Backpressure: instr_ready gates instr_valid; the ALU path has none.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_select;
    logic [3:0]       alu_imm;
    logic [WIDTH-1:0] alu_result;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] retired;
    logic [3:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output instr_valid, instr, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_select, alu_imm,
               done, illegal, retired, dbg_data
    );

    modport slave (
        input  instr_valid, instr, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_select, alu_imm,
               done, illegal, retired, dbg_data
    );

endinterface

// File: rtl/regfile_16x16.sv
// 16x16 register file: one synchronous write port, two operand reads and a debug read.
// Latency: reads combinational, write visible the cycle after we.
// Backpressure: none.
module regfile_16x16
    import alu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [3:0]       ra2,
    output logic [WIDTH-1:0] rd2,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != 4'd0) begin
            mem[waddr] <= wdata;
        end
    end

    // r0 reads as zero regardless of storage contents
    assign rd1      = (ra1 == 4'd0)      ? '0 : mem[ra1];
    assign rd2      = (ra2 == 4'd0)      ? '0 : mem[ra2];
    assign dbg_data = (dbg_addr == 4'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Serial decode/read/execute/write-back controller driving an external combinational ALU.
// Latency: 3 cycles accept->done; one instruction per 4 cycles.
// Backpressure: instr_ready is high only in IDLE.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);

    state_t           state, state_nxt;
    instr_t           ir;
    logic [WIDTH-1:0] opa, opb, res, rd1, rd2, retired_q;
    logic             legal, wb_we;
    logic             rdy_c, done_c, ill_c;
    logic [WIDTH-1:0] a_c, b_c;
    logic [3:0]       sel_c, imm_c;

    assign legal = is_legal(ir.op);

    regfile_16x16 u_rf (
        .clock    (clock),
        .reset    (reset),
        .we       (wb_we),
        .waddr    (ir.rd),
        .wdata    (res),
        .ra1      (ir.rs),
        .rd1      (rd1),
        .ra2      (ir.rt),
        .rd2      (rd2),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            ir        <= '0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (bus.instr_valid) ir <= unpack_instr(bus.instr);
                S_READ: begin
                    // I-type ops see their register operand on b, a is held at zero
                    if (is_rtype(ir.op)) begin
                        opa <= rd1;
                        opb <= rd2;
                    end else if (is_itype(ir.op)) begin
                        opa <= '0;
                        opb <= rd1;
                    end else begin
                        opa <= '0;
                        opb <= '0;
                    end
                end
                S_EXEC: res <= bus.alu_result;
                S_WB:   if (legal) retired_q <= retired_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        rdy_c     = 1'b0;
        done_c    = 1'b0;
        ill_c     = 1'b0;
        wb_we     = 1'b0;
        a_c       = '0;
        b_c       = '0;
        sel_c     = '0;
        imm_c     = '0;
        case (state)
            S_IDLE: begin
                rdy_c = 1'b1;
                if (bus.instr_valid) state_nxt = S_READ;
            end
            S_READ: state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt = S_WB;
                a_c       = opa;
                b_c       = opb;
                sel_c     = ir.op;
                imm_c     = is_itype(ir.op) ? ir.rt : 4'd0;
            end
            S_WB: begin
                state_nxt = S_IDLE;
                // a reset landing on the WB edge aborts the retire entirely
                done_c    = !reset;
                ill_c     = !reset && !legal;
                wb_we     = !reset && legal && (ir.rd != 4'd0);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.instr_ready = rdy_c;
    assign bus.done        = done_c;
    assign bus.illegal     = ill_c;
    assign bus.alu_a       = a_c;
    assign bus.alu_b       = b_c;
    assign bus.alu_select  = sel_c;
    assign bus.alu_imm     = imm_c;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded bench: stimulus pushes expected retirements, a monitor pops them on done.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Stand-in for the shared combinational ALU
    function automatic logic [15:0] alu_fn(input logic [3:0] s, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] imm);
        logic [15:0] iz;
        iz = {12'd0, imm};
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (b > iz) ? 16'd1 : 16'd0;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return b & iz;
            4'd7:  return b | iz;
            4'd8:  return b ^ iz;
            4'd9:  return b + iz;
            4'd10: return b - iz;
            default: return 16'd0;
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_select, bus.alu_a, bus.alu_b, bus.alu_imm);

    // Architectural result of one instruction: x=R[rs], y=R[rt], imm=low nibble
    function automatic int model(input int op, input int x, input int y, input int imm);
        case (op)
            0:  return (x + y) % 65536;
            1:  return (x - y + 65536) % 65536;
            2:  return (x > imm) ? 1 : 0;
            3:  return x & y;
            4:  return x | y;
            5:  return x ^ y;
            6:  return x & imm;
            7:  return x | imm;
            8:  return x ^ imm;
            9:  return (x + imm) % 65536;
            10: return (x - imm + 65536) % 65536;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        logic ill;
        int   ret;
        int   rd;
        int   val;
        int   acc;
    } exp_t;

    exp_t q[$];
    int   m_regs[16];
    int   m_ret = 0;
    int   ret_regs[16];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance with instr_valid still high
    task automatic send(input logic [15:0] w, output int acc);
        int   op, rd, rs, rt, budget;
        exp_t e;
        op = int'(w[15:12]);
        rd = int'(w[11:8]);
        rs = int'(w[7:4]);
        rt = int'(w[3:0]);
        if (op <= 10) begin
            if (rd != 0) m_regs[rd] = model(op, m_regs[rs], m_regs[rt], rt);
            m_ret = (m_ret + 1) % 65536;
        end
        e.ill = (op > 10);
        e.ret = m_ret;
        e.rd  = rd;
        e.val = m_regs[rd];
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        budget = 0;
        while (!bus.instr_ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.instr_ready) begin
            check("accept_timeout", 0, 1);
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc   = cyc;
        e.acc = acc;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic send_one(input logic [15:0] w);
        int acc;
        send(w, acc);
        bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        bus.instr_valid = 1'b0;
        while (q.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: samples 3 time units after each rising edge, owns dbg_addr
    initial begin
        int   pend_kind;
        int   sw_addr;
        exp_t pe;
        exp_t e;
        pend_kind    = 0;
        sw_addr      = 1;
        bus.dbg_addr = 4'd0;
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                pend_kind = 0;
                foreach (ret_regs[i]) ret_regs[i] = 0;
            end else begin
                if (pend_kind == 1) begin
                    check("retired", int'(bus.retired), pe.ret);
                    check("dbg_after_wb", int'(bus.dbg_data), pe.val);
                end else if (pend_kind == 2) begin
                    check("dbg_sweep", int'(bus.dbg_data), ret_regs[sw_addr]);
                end
                pend_kind = 0;
                if (bus.done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("illegal", int'(bus.illegal), int'(e.ill));
                        // done cycle closes at the third edge after the accepting edge
                        check("latency", cyc + 1 - e.acc, 3);
                        ret_regs[e.rd] = e.val;
                        pe             = e;
                        bus.dbg_addr   = 4'(e.rd);
                        pend_kind      = 1;
                    end
                end else begin
                    check("illegal_without_done", int'(bus.illegal), 0);
                    sw_addr      = (sw_addr % 15) + 1;
                    bus.dbg_addr = 4'(sw_addr);
                    pend_kind    = 2;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        foreach (m_regs[i]) m_regs[i] = 0;

        // Reset with a pending request that must not be taken
        bus.instr       = 16'h910F;
        bus.instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(bus.instr_ready), 1);
        check("rst_done", int'(bus.done), 0);
        check("rst_illegal", int'(bus.illegal), 0);
        check("rst_retired", int'(bus.retired), 0);
        check("rst_alu_a", int'(bus.alu_a), 0);
        check("rst_alu_b", int'(bus.alu_b), 0);
        check("rst_alu_select", int'(bus.alu_select), 0);
        check("rst_alu_imm", int'(bus.alu_imm), 0);
        bus.instr_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Preload and directed arithmetic
        send_one(16'h9105);
        send_one(16'h9203);
        send_one(16'h0312);
        send_one(16'h1421);
        send_one(16'h2514);
        send_one(16'h2515);
        drain();

        // Back-to-back with valid held high
        send(16'h0612, a0);
        send(16'h5763, a1);
        send(16'h7815, a2);
        bus.instr_valid = 1'b0;
        check("b2b_spacing_1", a1 - a0, 4);
        check("b2b_spacing_2", a2 - a1, 4);
        drain();

        // Illegal op and write to r0
        send_one(16'hC123);
        send_one(16'h9017);
        drain();

        // Reset during EXEC of op0 rd=6 rs=1 rt=2
        bus.instr       = 16'h0612;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("exec_alu_a", int'(bus.alu_a), m_regs[1]);
        check("exec_alu_b", int'(bus.alu_b), m_regs[2]);
        check("exec_alu_select", int'(bus.alu_select), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 0;
        m_ret = 0;
        @(negedge clk);
        check("abort_ready", int'(bus.instr_ready), 1);
        check("abort_retired", int'(bus.retired), 0);
        check("abort_done", int'(bus.done), 0);
        repeat (18) @(negedge clk);

        // Randomized traffic with random gaps
        for (int i = 0; i < 80; i++) begin
            logic [15:0] w;
            int          acc, gap;
            w   = 16'($urandom);
            gap = $urandom_range(0, 2);
            send(w, acc);
            if (gap != 0) begin
                bus.instr_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        drain();
        repeat (18) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that accepts 16-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal 16x16 register file, drives the shared 16-bit combinational ALU through its operand, select and immediate ports, and writes the registered result back. It sits between the instruction source and the ALU and is the only master of the ALU's inputs.

## Interface
- NUM_REGS, 16, register file depth; fixed at 16 because register fields are 4 bits.
- WIDTH, 16, datapath width.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- instr_valid  in  1  instruction word on instr is valid.
- instr_ready  out  1  sequencer can accept an instruction (high only in IDLE).
- instr  in  16  [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm.
- alu_a  out  16  ALU operand a.
- alu_b  out  16  ALU operand b.
- alu_select  out  4  ALU operation select (equal to op).
- alu_imm  out  4  ALU immediate.
- alu_result  in  16  ALU combinational result.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse with done when op is 11..15.
- retired  out  16  count of retired legal instructions; wraps 0xFFFF->0.
- dbg_addr  in  4  debug read address.
- dbg_data  out  16  combinational read of register dbg_addr; r0 reads 0.

## Operation
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions exist.
- IDLE: instr_ready=1. instr_valid && instr_ready latches instr and moves to READ. Otherwise the FSM stays in IDLE.
- READ: latch operand registers opa, opb from the register file.
  - R-type ops 0,1,3,4,5: opa=R[rs], opb=R[rt].
  - I-type ops 2,6..10: opa=0, opb=R[rs], imm=instr[3:0].
  - Ops 11..15 (illegal): opa=opb=0.
- EXEC: alu_a=opa, alu_b=opb, alu_select=op, alu_imm=imm. alu_result is captured into res at the end of the cycle.
- WB: if op is legal and rd!=0, R[rd]<=res. done=1. illegal=1 if op>=11. retired increments on legal ops only.
- Outside EXEC, alu_a, alu_b, alu_select and alu_imm are driven to 0.
- r0 is hardwired zero. Writes to rd=0 are discarded but still count as retired.
- Reads in READ see all writes from previously retired instructions. No forwarding is needed because the design is strictly serial.
- Op semantics (implemented by the ALU):
  - 0 add, 1 sub, 2 set 1 if b>imm else 0 (unsigned), 3 and, 4 or, 5 xor.
  - 6 andi, 7 ori, 8 xori, 9 addi, 10 subi; imm is zero-extended.
  - All arithmetic is mod 2^16.

## Timing
- Handshake accepted at edge N. READ in cycle N+1, EXEC in N+2, WB in N+3 (done high). instr_ready is high again in N+4.
- Latency: 3 cycles from accept to done. Maximum throughput: 1 instruction per 4 cycles.
- instr_valid held high continuously is accepted at N, N+4, N+8, and so on. instr is don't-care while instr_ready=0.
- Reset values: state=IDLE, instr_ready=1, done=0, illegal=0, retired=0, alu_* outputs=0, all registers=0.
- Reset asserted mid-instruction aborts it: no write-back, no done, no retired increment. The FSM is in IDLE on the cycle after reset deasserts.
- reset has priority over the handshake. instr_valid during a reset cycle is not accepted.
- dbg_data is combinational. It reflects a WB write starting the cycle after WB.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=0 .. OP_SUBI=10 and OP_LAST_LEGAL=10;
  - FSM state encoding S_IDLE, S_READ, S_EXEC, S_WB (2 bits);
  - instruction field bit positions.
- One sub-module: regfile_16x16. It has one synchronous write port, two combinational read ports plus the debug read port, and hardwired r0.
- The ALU is instantiated by the parent alongside the sequencer, not inside it.

## Test plan
- Reset, then preload via instructions: op9 rd=1 rs=0 imm=5 and op9 rd=2 rs=0 imm=3 -> R1=5, R2=3, retired=2, each done 3 cycles after accept.
- op0 rd=3 rs=1 rt=2 -> R3=8. op1 rd=4 rs=2 rt=1 -> R4=0xFFFE (wrap). dbg_data matches both.
- op2 rd=5 rs=1 imm=4 -> R5=1. Same with imm=5 -> R5=0 (strict greater-than).
- instr_valid held high with 3 back-to-back instructions -> accepts spaced exactly 4 cycles apart, instr_ready low in between.
- op12 -> illegal and done pulse together, no register changes, retired unchanged. rd=0 write -> R0 stays 0, retired increments.
- Assert reset during EXEC of op0 rd=6 -> R6 unchanged, no done, retired=0, instr_ready=1 the cycle after reset deasserts.
